// File: rtl/match_event_monitor.sv
// Match event monitor: counts detector match pulses, tracks last/minimum
// inter-match gap and raises a sticky threshold interrupt.
module match_event_monitor #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             z_in,
  input  logic             clr,
  input  logic [CNT_W-1:0] thresh,
  output logic [CNT_W-1:0] match_cnt,
  output logic [GAP_W-1:0] last_gap,
  output logic [GAP_W-1:0] min_gap,
  output logic             gap_valid,
  output logic             irq,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GAP_W-1:0] GAP_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0] last_gap_q, last_gap_d;
  logic [GAP_W-1:0] min_gap_q, min_gap_d;
  logic             have_prev_q, have_prev_d;
  logic             gap_valid_q, gap_valid_d;
  logic             irq_q, irq_d;
  logic             busy_q, busy_d;

  // Counter, gap timer and gap statistics; clr wins over a coincident match.
  always_comb begin
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    last_gap_d  = last_gap_q;
    min_gap_d   = min_gap_q;
    have_prev_d = have_prev_q;
    gap_valid_d = gap_valid_q;
    if (clr) begin
      cnt_d       = '0;
      timer_d     = '0;
      last_gap_d  = '0;
      min_gap_d   = GAP_MAX;
      have_prev_d = 1'b0;
      gap_valid_d = 1'b0;
    end else if (en) begin
      if (z_in) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        timer_d     = GAP_W'(1);
        have_prev_d = 1'b1;
        if (have_prev_q) begin
          last_gap_d  = timer_q;
          gap_valid_d = 1'b1;
          if (timer_q < min_gap_q) min_gap_d = timer_q;
        end
      end else if (have_prev_q && (timer_q != GAP_MAX)) begin
        timer_d = timer_q + GAP_W'(1);
      end
    end
  end

  // Next state; the ARMED compare uses the post-update count so irq aligns with the count.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = en ? ST_ARMED : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (en) state_d = ST_ARMED;
        ST_ARMED: begin
          if ((thresh != '0) && (cnt_d >= thresh)) state_d = ST_FIRED;
          else if (!en)                            state_d = ST_IDLE;
        end
        ST_FIRED: state_d = ST_FIRED;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Status flags decoded from the next state so they are flop outputs.
  always_comb begin
    irq_d  = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      ST_ARMED: busy_d = 1'b1;
      ST_FIRED: begin
        busy_d = 1'b1;
        irq_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      last_gap_q  <= '0;
      min_gap_q   <= GAP_MAX;
      have_prev_q <= 1'b0;
      gap_valid_q <= 1'b0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      last_gap_q  <= last_gap_d;
      min_gap_q   <= min_gap_d;
      have_prev_q <= have_prev_d;
      gap_valid_q <= gap_valid_d;
      irq_q       <= irq_d;
      busy_q      <= busy_d;
    end
  end

  assign match_cnt = cnt_q;
  assign last_gap  = last_gap_q;
  assign min_gap   = min_gap_q;
  assign gap_valid = gap_valid_q;
  assign irq       = irq_q;
  assign busy      = busy_q;

endmodule
